// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles 32-bit instructions from two
// halfword reads (high half first) and hands them to decode over valid/ready.
module fetch_stage #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [15:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [1:0] S_HI   = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);
  localparam logic [31:0]       NOP    = 32'h2800_0000;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       hi_buf;
  logic              take;

  assign take = instr_valid && instr_ready;

  // pc is always even, so the low-half address is just pc with bit 0 set.
  always_comb begin
    imem_addr  = (state == S_LO) ? (pc | PC_ONE) : pc;
    imem_rd_en = 1'b0;
    case (state)
      S_HI:    imem_rd_en = 1'b1;
      S_LO:    imem_rd_en = 1'b1;
      S_HOLD:  imem_rd_en = take;
      default: imem_rd_en = 1'b0;
    endcase
    if (reset || redirect)
      imem_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_HI;
      pc          <= RESET_PC;
      hi_buf      <= 16'h0000;
      instr       <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      // Restarting in S_HI means the halfword returning next cycle is ignored.
      pc          <= redirect_pc & ~PC_ONE;
      instr_valid <= 1'b0;
      state       <= S_HI;
    end else begin
      case (state)
        S_HI: state <= S_LO;
        S_LO: begin
          hi_buf <= imem_rdata;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          instr       <= {hi_buf, imem_rdata};
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + PC_TWO;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          // The next high-half read was issued this cycle, so skip S_HI.
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_LO;
          end
        end
        default: state <= S_HI;
      endcase
    end
  end

endmodule
